bram_host_master: RTL

BRAM_HOST_MASTER -- requirements
Module: bram_host_master

---
 rtl/bram_host_master_pkg.sv | 25 ++
 rtl/bram_host_master_sync_fifo.sv | 54 +++++
 rtl/bram_host_master.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bram_host_master_pkg.sv
// Shared definitions for the host-side BRAM burst master: bus widths,
// write-strobe constant, FSM state type and address stepping helper.
package tpu_host_defs;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int WE_W   = 4;

  localparam logic [WE_W-1:0] WE_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RD    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Address arithmetic wraps naturally modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_advance(input logic [ADDR_W-1:0] a,
                                                     input int unsigned step);
    return a + ADDR_W'(step);
  endfunction

endpackage

// File: rtl/bram_host_master_sync_fifo.sv
// Synchronous FIFO with occupancy count, used as the read-return buffer.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_push = push && (r_count != CNT_W'(DEPTH));
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_do_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bram_host_master.sv
// Host command to BRAM burst master: streams write words onto the BRAM port,
// issues flow-controlled reads and returns read data through a small FIFO.
module bram_host_master
  import tpu_host_defs::*;
#(
  parameter int RD_LATENCY    = 2,
  parameter int ADDR_STEP     = 4,
  parameter int RD_FIFO_DEPTH = RD_LATENCY + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_wr_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] axi_addr_a,
  output logic [DATA_W-1:0] axi_wrdata_a,
  output logic              axi_en_a,
  output logic [WE_W-1:0]   axi_we_a,
  output logic              axi_rst_a,
  input  logic [DATA_W-1:0] axi_rddata_a
);

  localparam int CNT_W = $clog2(RD_FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(RD_FIFO_DEPTH + RD_LATENCY + 2);

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_W-1:0]     r_addr;
  logic [LEN_W-1:0]      r_remaining;
  logic [ADDR_W-1:0]     r_axi_addr;
  logic [DATA_W-1:0]     r_axi_wrdata;
  logic                  r_axi_en;
  logic [WE_W-1:0]       r_axi_we;
  logic                  r_axi_rst;
  logic                  r_done;
  logic [RD_LATENCY-1:0] r_tags;

  logic                  w_cmd_hs;
  logic                  w_wr_hs;
  logic                  w_issue;
  logic                  w_pop;
  logic                  w_drain_done;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [OCC_W-1:0]      w_in_flight;
  logic [OCC_W-1:0]      w_occupancy;

  assign cmd_ready_o  = (r_state == ST_IDLE);
  assign busy_o       = (r_state != ST_IDLE);
  assign wr_ready_o   = (r_state == ST_WR);
  assign rd_valid_o   = !w_fifo_empty;
  assign done_o       = r_done || w_drain_done;
  assign axi_addr_a   = r_axi_addr;
  assign axi_wrdata_a = r_axi_wrdata;
  assign axi_en_a     = r_axi_en;
  assign axi_we_a     = r_axi_we;
  assign axi_rst_a    = r_axi_rst;

  assign w_cmd_hs = cmd_valid_i && cmd_ready_o;
  assign w_wr_hs  = wr_valid_i && wr_ready_o;
  assign w_pop    = rd_valid_o && rd_ready_i;

  // Reads on the port or in the tag pipe; each will land in the FIFO.
  always_comb begin
    w_in_flight = OCC_W'(r_axi_en && (r_axi_we == '0));
    for (int unsigned i = 0; i < RD_LATENCY; i++)
      w_in_flight = w_in_flight + OCC_W'(r_tags[i]);
  end

  // A pop this cycle frees its slot in time for a newly issued read.
  assign w_occupancy = w_in_flight + OCC_W'(w_fifo_count) - OCC_W'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_hs && (cmd_len_i != '0))
          w_state_next = cmd_wr_i ? ST_WR : ST_RD;
      end
      ST_WR: begin
        if (w_wr_hs && (r_remaining == LEN_W'(1)))
          w_state_next = ST_IDLE;
      end
      ST_RD: begin
        w_issue = (w_occupancy < OCC_W'(RD_FIFO_DEPTH));
        if (w_issue && (r_remaining == LEN_W'(1)))
          w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((w_in_flight == '0) && (w_fifo_count == CNT_W'(1)) && w_pop) begin
          w_drain_done = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_remaining  <= '0;
      r_axi_addr   <= '0;
      r_axi_wrdata <= '0;
      r_axi_en     <= 1'b0;
      r_axi_we     <= '0;
      r_axi_rst    <= 1'b1;
      r_done       <= 1'b0;
      r_tags       <= '0;
    end else begin
      r_axi_rst <= 1'b0;
      r_done    <= 1'b0;
      r_axi_en  <= 1'b0;
      r_axi_we  <= '0;
      if (w_cmd_hs) begin
        r_addr      <= cmd_addr_i;
        r_remaining <= cmd_len_i;
        if (cmd_len_i == '0) r_done <= 1'b1;
      end
      if (w_wr_hs) begin
        r_axi_en     <= 1'b1;
        r_axi_we     <= WE_ALL;
        r_axi_addr   <= r_addr;
        r_axi_wrdata <= wr_data_i;
        r_addr       <= addr_advance(r_addr, ADDR_STEP);
        r_remaining  <= r_remaining - LEN_W'(1);
        if (r_remaining == LEN_W'(1)) r_done <= 1'b1;
      end
      if (w_issue) begin
        r_axi_en    <= 1'b1;
        r_axi_addr  <= r_addr;
        r_addr      <= addr_advance(r_addr, ADDR_STEP);
        r_remaining <= r_remaining - LEN_W'(1);
      end
      r_tags[0] <= r_axi_en && (r_axi_we == '0);
      for (int unsigned i = 1; i < RD_LATENCY; i++)
        r_tags[i] <= r_tags[i-1];
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RD_FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_tags[RD_LATENCY-1]),
    .push_data (axi_rddata_a),
    .pop       (w_pop),
    .pop_data  (rd_data_o),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

endmodule
